// File: rtl/sync_barrier_pkg.sv
// Shared accelerator package: barrier controller state encoding.
package sync_barrier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } barrier_state_t;

endpackage

// File: rtl/barrier_timer.sv
// Barrier timeout counter; expired is high while the count sits at all ones.
// Only instantiated when SYNC_TIMEOUT_EN is defined.
module barrier_timer #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    // clear wins over count_en; the count holds once it saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = &count;

endmodule

// File: rtl/sync_barrier.sv
// Barrier and kernel-completion controller for NUM_CORES cores.
// Optional barrier timeout is enabled by defining SYNC_TIMEOUT_EN.
module sync_barrier
    import sync_barrier_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] sync_req,
    input  logic [NUM_CORES-1:0] exit_req,
    output logic [NUM_CORES-1:0] sync_release,
    output logic [NUM_CORES-1:0] core_active,
    output logic [NUM_CORES-1:0] arrived,
    output logic                 busy,
    output logic                 kernel_done,
    output logic                 timeout_err,
    output barrier_state_t       dbg_state
);

    barrier_state_t       state, state_n;
    logic [NUM_CORES-1:0] active_n, arrived_n, release_n;
    logic                 done_n;
    logic                 timeout_fire;

    always_comb begin
        state_n   = state;
        active_n  = core_active;
        arrived_n = arrived;
        release_n = '0;
        done_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_RUN;
                    active_n  = '1;
                    arrived_n = '0;
                end
            end
            ST_RUN: begin
                // an exit in the same cycle as a sync drops the core from both masks
                active_n  = core_active & ~exit_req;
                arrived_n = (arrived | sync_req) & active_n;
                if (active_n == '0) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else if ((arrived_n == active_n) || timeout_fire) begin
                    state_n   = ST_RELEASE;
                    release_n = arrived_n;
                end
            end
            ST_RELEASE: begin
                // sync_req is still high from the released cores; ignore it here
                active_n  = core_active & ~exit_req;
                arrived_n = '0;
                if (active_n == '0) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                active_n  = '0;
                arrived_n = '0;
                state_n   = ST_IDLE;
            end
            default: begin
                state_n   = ST_IDLE;
                active_n  = '0;
                arrived_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            core_active  <= '0;
            arrived      <= '0;
            sync_release <= '0;
            kernel_done  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            core_active  <= active_n;
            arrived      <= arrived_n;
            sync_release <= release_n;
            kernel_done  <= done_n;
            busy         <= (state_n != ST_IDLE);
        end
    end

    assign dbg_state = state;

`ifdef SYNC_TIMEOUT_EN
    logic tmo_count_en, tmo_clear, tmo_expired;

    assign tmo_count_en = (state == ST_RUN) && (arrived != '0);
    assign tmo_clear    = (state != ST_RUN) || (state_n == ST_RELEASE);
    assign timeout_fire = (state == ST_RUN) && tmo_expired;

    barrier_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (tmo_count_en),
        .clear    (tmo_clear),
        .expired  (tmo_expired)
    );

    // sticky until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            timeout_err <= 1'b0;
        end else if (timeout_fire && (state_n == ST_RELEASE)) begin
            timeout_err <= 1'b1;
        end
    end
`else
    logic [TIMEOUT_W-1:0] unused_tmo_count;

    assign unused_tmo_count = '0;
    assign timeout_fire     = 1'b0;
    assign timeout_err      = 1'b0;
`endif

endmodule
